// File: rtl/toggle_hs_rx.sv
// Two-phase (toggle) handshake receiver.
// Synchronized requests are accepted into a small FIFO drained by valid/ready.
module toggle_hs_rx #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_tgl,
  input  logic [DATA_W-1:0]        din,
  output logic                     ack_tgl,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               evt_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  typedef enum logic {
    IDLE,
    STALL
  } state_e;

  state_e            state_q, state_d;
  logic              s1_q, s1_d;
  logic              s2_q, s2_d;
  logic              req_seen_q, req_seen_d;
  logic              ack_q, ack_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic [7:0]        evt_q, evt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic pending;
  logic full;
  logic push;
  logic pop;

  assign dout_valid = (level_q != '0);
  assign dout       = mem_q[rd_ptr_q];
  assign ack_tgl    = ack_q;
  assign level      = level_q;
  assign evt_cnt    = evt_q;

  assign pending = (s2_q != req_seen_q);
  assign full    = (level_q == LVL_FULL);
  assign pop     = dout_valid && dout_ready;

  always_comb begin
    state_d    = state_q;
    s1_d       = req_tgl;
    s2_d       = s1_q;
    req_seen_d = req_seen_q;
    ack_d      = ack_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    evt_d      = evt_q;
    push       = 1'b0;

    // full comes from the registered level, so a pop never
    // unblocks a push in the same cycle
    unique case (state_q)
      IDLE: begin
        if (pending) begin
          if (full) state_d = STALL;
          else      push    = 1'b1;
        end
      end
      STALL: begin
        if (!pending) begin
          state_d = IDLE;
        end else if (!full) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
    endcase

    if (push) begin
      req_seen_d = s2_q;
      ack_d      = ~ack_q;
      evt_d      = evt_q + 8'd1;
      wr_ptr_d   = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      req_seen_q <= 1'b0;
      ack_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      evt_q      <= '0;
    end else begin
      state_q    <= state_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      req_seen_q <= req_seen_d;
      ack_q      <= ack_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      evt_q      <= evt_d;
    end
  end

  // Storage needs no reset: level gates every read.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: tb/tb_toggle_hs_rx.sv
// Bench for toggle_hs_rx: toggle sender model, FIFO scoreboard
// and directed latency/stall/reset checks plus a random phase.
module tb_toggle_hs_rx;

  logic       clk;
  logic       reset;
  logic       req_tgl;
  logic [7:0] din;
  logic       ack_tgl;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [2:0] level;
  logic [7:0] evt_cnt;

  int         n_tests;
  int         n_fail;
  bit         rand_ready;
  logic [7:0] exp_q[$];
  int         n_acc;

  toggle_hs_rx #(.DATA_W(8), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_tgl    (req_tgl),
    .din        (din),
    .ack_tgl    (ack_tgl),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .level      (level),
    .evt_cnt    (evt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!reset && dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL pop_unexpected: got %0h expected none", dout);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("dout_order", 32'(dout), 32'(e));
        end
      end
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    req_tgl    = 1'b0;
    dout_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
    n_acc = 0;
  endtask

  task automatic issue(input logic [7:0] d);
    din     = d;
    req_tgl = ~req_tgl;
    exp_q.push_back(d);
  endtask

  task automatic send(input logic [7:0] d);
    logic a0;
    logic exp_ack;
    a0 = ack_tgl;
    issue(d);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (ack_tgl != a0) break;
    end
    exp_ack = ~a0;
    chk("ack_handshake", 32'(ack_tgl), 32'(exp_ack));
    n_acc++;
  endtask

  initial begin
    logic a0;
    logic exp_ack;
    n_tests    = 0;
    n_fail     = 0;
    rand_ready = 1'b0;
    reset      = 1'b1;
    req_tgl    = 1'b0;
    din        = '0;
    dout_ready = 1'b0;
    n_acc      = 0;

    fork
      monitor();
      begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
      end
    join_none

    // reset state
    do_reset();
    chk("rst_ack", 32'(ack_tgl), 0);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_evt", 32'(evt_cnt), 0);

    // single transfer, exact latency
    din     = 8'hA5;
    req_tgl = 1'b1;
    exp_q.push_back(8'hA5);
    tick();
    chk("lat_k", 32'(ack_tgl), 0);
    tick();
    chk("lat_k1", 32'(ack_tgl), 0);
    tick();
    chk("lat_k2_ack", 32'(ack_tgl), 1);
    chk("lat_dout", 32'(dout), 32'hA5);
    chk("lat_valid", 32'(dout_valid), 1);
    chk("lat_level", 32'(level), 1);
    chk("lat_evt", 32'(evt_cnt), 1);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk("drain_level", 32'(level), 0);

    // fill and stall
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i));
    a0 = ack_tgl;
    issue(8'h14);
    repeat (8) tick();
    chk("stall_ack", 32'(ack_tgl), 32'(a0));
    chk("stall_level", 32'(level), 4);
    chk("stall_evt", 32'(evt_cnt), 5);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk("pop_only_level", 32'(level), 3);
    chk("pop_only_ack", 32'(ack_tgl), 32'(a0));
    tick();
    exp_ack = ~a0;
    chk("unstall_level", 32'(level), 4);
    chk("unstall_ack", 32'(ack_tgl), 32'(exp_ack));
    chk("unstall_evt", 32'(evt_cnt), 6);

    // reset while stalled with a pending request
    a0 = ack_tgl;
    issue(8'h15);
    repeat (4) tick();
    chk("stall2_ack", 32'(ack_tgl), 32'(a0));
    do_reset();
    chk("midrst_level", 32'(level), 0);
    chk("midrst_valid", 32'(dout_valid), 0);
    chk("midrst_ack", 32'(ack_tgl), 0);
    chk("midrst_evt", 32'(evt_cnt), 0);
    repeat (4) tick();
    chk("midrst_discard", 32'(level), 0);

    // streaming
    dout_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(8'(i));
    repeat (4) tick();
    chk("stream_evt", 32'(evt_cnt), 10);
    chk("stream_level", 32'(level), 0);
    chk("stream_sb_empty", 32'(exp_q.size()), 0);

    // simultaneous push and pop at level 2
    dout_ready = 1'b0;
    send(8'h31);
    send(8'h32);
    chk("sim_pre_level", 32'(level), 2);
    a0 = ack_tgl;
    issue(8'h33);
    tick();
    tick();
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    exp_ack = ~a0;
    chk("sim_level", 32'(level), 2);
    chk("sim_dout", 32'(dout), 32'h32);
    chk("sim_ack", 32'(ack_tgl), 32'(exp_ack));
    chk("sim_evt", 32'(evt_cnt), 13);
    dout_ready = 1'b1;
    repeat (4) tick();
    dout_ready = 1'b0;
    chk("sim_drain", 32'(level), 0);

    // request held high through reset release
    reset   = 1'b1;
    req_tgl = 1'b1;
    din     = 8'h77;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'h77);
    repeat (3) tick();
    chk("hold_ack", 32'(ack_tgl), 1);
    chk("hold_evt", 32'(evt_cnt), 1);
    chk("hold_level", 32'(level), 1);
    repeat (3) tick();
    chk("hold_once", 32'(evt_cnt), 1);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    n_acc = 1;

    // random traffic, enough to wrap evt_cnt and pointers
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
      send(8'($urandom));
    end
    rand_ready = 1'b0;
    dout_ready = 1'b1;
    repeat (10) tick();
    chk("rand_evt", 32'(evt_cnt), 32'(8'(n_acc)));
    chk("rand_level", 32'(level), 0);
    chk("rand_sb_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/toggle_hs_rx.md
TOGGLE_HS_RX -- requirements
Module: toggle_hs_rx

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the width of the data path.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of receive FIFO entries and SHALL be a power of two, at least 2.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 req_tgl  input  1  SHALL be the two-phase request from the sender; each level change is one transfer.
REQ-006 din  input  DATA_W  SHALL be the sender data; the sender holds it stable from its req_tgl change until the matching ack_tgl change.
REQ-007 ack_tgl  output  1  SHALL be the two-phase acknowledge; each level change accepts one transfer.
REQ-008 dout  output  DATA_W  SHALL be the FIFO head data.
REQ-009 dout_valid  output  1  SHALL be high whenever the FIFO is non-empty.
REQ-010 dout_ready  input  1  SHALL be the downstream accept signal.
REQ-011 level  output  clog2(DEPTH)+1  SHALL be the FIFO occupancy, in the range 0..DEPTH.
REQ-012 evt_cnt  output  8  SHALL count accepted transfers, modulo 256.

Function
REQ-013 The synchronizer SHALL pass req_tgl through two flops: s1 <= req_tgl, then s2 <= s1.
REQ-014 Register req_seen SHALL hold the last accepted request level; pending = (s2 != req_seen).
REQ-015 FSM states: IDLE (pending=0) and STALL (pending=1 and FIFO full); the ACCEPT action occurs in any cycle with pending=1 and not full.
REQ-016 ACCEPT SHALL be a single-cycle action: push din, set req_seen <= s2, toggle ack_tgl, increment evt_cnt.
REQ-017 Latency: if req_tgl changes before clk edge k, s2 updates at edge k+1, ACCEPT occurs at edge k+2, and ack_tgl is changed after edge k+2.
REQ-018 No ACCEPT SHALL occur while full; the block SHALL stay in STALL and hold ack_tgl until a pop frees an entry.
REQ-019 A pop SHALL occur when dout_valid && dout_ready; the head pointer advances, wrapping modulo DEPTH.
REQ-020 full SHALL be evaluated from the registered level; a pop and a stalled push in the same cycle SHALL pop only, and the ACCEPT follows on the next edge.
REQ-021 Simultaneous push and pop with 0 < level < DEPTH SHALL leave level unchanged and advance both pointers.
REQ-022 The write and read pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or underflow below 0.
REQ-023 A pop on empty SHALL be ignored, because dout_valid=0.
REQ-024 At most one transfer SHALL be accepted per req_tgl change; the sender issues no new change before it sees ack_tgl change.
REQ-025 dout SHALL equal the FIFO head entry whenever dout_valid=1, and is don't-care otherwise.

Reset
REQ-026 When reset=1, the block SHALL load s1=0, s2=0, req_seen=0, ack_tgl=0, both pointers=0, level=0, dout_valid=0, evt_cnt=0, and state IDLE.
REQ-027 Reset SHALL take priority over every other action in the same cycle.
REQ-028 Reset asserted mid-transfer SHALL discard any pending request and all FIFO contents.
REQ-029 A req_tgl held at 1 through reset release SHALL be seen as one new transfer.
REQ-030 The sender SHALL be reset together with this block so that both ends start at level 0.

Verification
REQ-031 Single transfer: reset, req_tgl 0->1 with din=0xA5 before edge k -> ack_tgl 0->1 after edge k+2, dout=0xA5, dout_valid=1, level=1, evt_cnt=1.
REQ-032 Fill and stall, DEPTH=4, dout_ready=0: 5 transfers -> ack toggles 4 times, level=4, 5th req pending with ack_tgl unchanged; one pop -> 5th ACCEPT on the next edge, level back to 4.
REQ-033 Streaming with dout_ready=1: 10 transfers 0x00..0x09 -> dout order 0x00..0x09, no loss or duplication, evt_cnt=10.
REQ-034 Wrap: 256 transfers -> evt_cnt returns to 0; pointers wrap with data order preserved.
REQ-035 Reset mid-stall with level=4 and a pending req -> after reset level=0, dout_valid=0, ack_tgl=0, evt_cnt=0.
REQ-036 Simultaneous push and pop at level=2 -> level stays 2, dout advances to the next entry, ack_tgl toggles.
